bsv_credit_arb: RTL and testbench

BSV_CREDIT_ARB -- requirements
Module: bsv_credit_arb

---
 rtl/bsv_credit_pkg.sv | 21 ++
 rtl/BsvCounter.sv | 51 +++++
 rtl/bsv_credit_arb.sv | 136 +++++++++++++
 tb/tb_bsv_credit_arb.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bsv_credit_pkg.sv
`default_nettype none
// ============================================================================
// Module : bsv_credit_pkg
// Brief  : Shared FSM state encoding and requester indices for the credit
//          arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package bsv_credit_pkg;

  // Arbiter run/hold state; one bit is enough for the two states
  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_t;

  // Requester indices, also the values held by the round-robin pointer
  localparam logic REQ_IDX0 = 1'b0;
  localparam logic REQ_IDX1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/BsvCounter.sv
`default_nettype none
// ============================================================================
// Module : BsvCounter
// Brief  : Loadable up/down counter primitive. Two independent add ports,
//          a set-current port (C) and a set-final port (F) that overrides
//          everything else.
// Rev    : 1.0  initial release
// ============================================================================
module BsvCounter #(
  parameter int width = 8,
  parameter int init  = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [width-1:0] DATA_A,
  input  logic             ADDA,
  input  logic [width-1:0] DATA_B,
  input  logic             ADDB,
  input  logic [width-1:0] DATA_C,
  input  logic             SETC,
  input  logic [width-1:0] DATA_F,
  input  logic             SETF,
  output logic [width-1:0] Q_OUT
);

  localparam logic [width-1:0] c_init = width'(init);

  logic [width-1:0] r_q;
  logic [width-1:0] w_base;
  logic [width-1:0] w_add_a;
  logic [width-1:0] w_add_b;

  assign w_base  = SETC ? DATA_C : r_q;
  assign w_add_a = ADDA ? DATA_A : '0;
  assign w_add_b = ADDB ? DATA_B : '0;

  // Count register: SETF wins, otherwise base plus both addends (modulo 2^width)
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_q <= c_init;
    end else if (SETF) begin
      r_q <= DATA_F;
    end else begin
      r_q <= w_base + w_add_a + w_add_b;
    end
  end

  assign Q_OUT = r_q;

endmodule
`default_nettype wire

// File: rtl/bsv_credit_arb.sv
`default_nettype none
// ============================================================================
// Module : bsv_credit_arb
// Brief  : Two-requester credit arbiter. Grants are decided from the
//          registered credit count, pulsed one cycle later, and the granted
//          amount is debited at the same edge. Returns, loads and saturation
//          are folded into a single BsvCounter instance.
// Rev    : 1.0  initial release
// ============================================================================
module bsv_credit_arb
  import bsv_credit_pkg::*;
#(
  parameter int width    = 8,
  parameter int init     = 4,
  parameter int max_cred = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic [width-1:0] AMT0,
  input  logic             REQ1,
  input  logic [width-1:0] AMT1,
  output logic             GNT0,
  output logic             GNT1,
  input  logic             RET_EN,
  input  logic [width-1:0] RET_AMT,
  input  logic             LOAD_EN,
  input  logic [width-1:0] LOAD_VAL,
  input  logic             FREEZE,
  output logic [width-1:0] CREDITS,
  output logic             ERR
);

  localparam logic [width-1:0] c_max     = width'(max_cred);
  localparam logic [width:0]   c_max_ext = (width+1)'(max_cred);

  arb_state_t r_state;
  logic       r_gnt0;
  logic       r_gnt1;
  logic       r_ptr;
  logic       r_err;

  logic [width-1:0] w_credits;
  logic             w_run_ok;
  logic             w_el0;
  logic             w_el1;
  logic             w_pick0;
  logic             w_pick1;
  logic             w_grant;
  logic [width-1:0] w_amt_sel;
  logic [width-1:0] w_neg_amt;
  logic [width-1:0] w_ret;
  logic [width+1:0] w_sum;
  logic             w_unf;
  logic             w_ovf;
  logic             w_load_big;
  logic             w_setf;
  logic [width-1:0] w_data_f;
  logic             w_err_set;

  // Grants only from RUN, with no freeze or load pending this cycle; a
  // requester whose grant pulse is still out cannot be granted again.
  assign w_run_ok = (r_state == ST_RUN) && !FREEZE && !LOAD_EN;
  assign w_el0    = REQ0 && !r_gnt0 && (AMT0 <= w_credits) && (AMT0 != '0) && w_run_ok;
  assign w_el1    = REQ1 && !r_gnt1 && (AMT1 <= w_credits) && (AMT1 != '0) && w_run_ok;

  // Pointer only breaks ties; a lone eligible requester always wins
  assign w_pick0   = w_el0 && (!w_el1 || (r_ptr == REQ_IDX0));
  assign w_pick1   = w_el1 && (!w_el0 || (r_ptr == REQ_IDX1));
  assign w_grant   = w_pick0 || w_pick1;
  assign w_amt_sel = w_pick1 ? AMT1 : (w_pick0 ? AMT0 : '0);
  assign w_neg_amt = '0 - w_amt_sel;
  assign w_ret     = RET_EN ? RET_AMT : '0;

  // Two extra bits: the MSB flags a negative result, bit width catches overflow
  assign w_sum = {2'b00, w_credits} + {2'b00, w_ret} - {2'b00, w_amt_sel};
  assign w_unf = w_sum[width+1];
  assign w_ovf = !w_unf && (w_sum[width:0] > c_max_ext);

  assign w_load_big = ({1'b0, LOAD_VAL} > c_max_ext);
  assign w_setf     = LOAD_EN || w_ovf || w_unf;
  assign w_data_f   = LOAD_EN ? (w_load_big ? c_max : LOAD_VAL)
                              : (w_ovf ? c_max : '0);
  assign w_err_set  = LOAD_EN ? w_load_big : (w_ovf || w_unf);

  BsvCounter #(
    .width (width),
    .init  (init)
  ) u_count (
    .CLK    (CLK),
    .RST    (RST),
    .DATA_A (w_ret),
    .ADDA   (RET_EN && !LOAD_EN),
    .DATA_B (w_neg_amt),
    .ADDB   (w_grant),
    .DATA_C ('0),
    .SETC   (1'b0),
    .DATA_F (w_data_f),
    .SETF   (w_setf),
    .Q_OUT  (w_credits)
  );

  // Run/hold FSM with registered grant pulses, round-robin pointer and sticky error
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= ST_RUN;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_ptr   <= REQ_IDX0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN:  if (FREEZE)  r_state <= ST_HOLD;
        ST_HOLD: if (!FREEZE) r_state <= ST_RUN;
        default: r_state <= ST_RUN;
      endcase
      r_gnt0 <= w_pick0;
      r_gnt1 <= w_pick1;
      if (w_pick0) begin
        r_ptr <= REQ_IDX1;
      end else if (w_pick1) begin
        r_ptr <= REQ_IDX0;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign GNT0    = r_gnt0;
  assign GNT1    = r_gnt1;
  assign CREDITS = w_credits;
  assign ERR     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bsv_credit_arb.sv
`default_nettype none
// ============================================================================
// Module : tb_bsv_credit_arb
// Brief  : Self-checking bench for bsv_credit_arb: directed scenarios plus a
//          randomized run against a cycle-level behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_bsv_credit_arb;

  localparam int W    = 8;
  localparam int INIT = 4;
  localparam int MAXC = 255;

  logic         clk;
  logic         rst;
  logic         req [2];
  logic [W-1:0] amt [2];
  logic         gnt0, gnt1;
  logic         ret_en;
  logic [W-1:0] ret_amt;
  logic         load_en;
  logic [W-1:0] load_val;
  logic         freeze;
  logic [W-1:0] credits;
  logic         err;

  int    n_cmp = 0;
  int    n_bad = 0;
  string phase = "init";

  // Behavioural model state: values the DUT registers should hold
  int m_cred;
  int m_ptr;
  bit m_err;
  bit m_hold;
  bit m_gnt [2];

  bsv_credit_arb #(.width(W), .init(INIT), .max_cred(MAXC)) dut (
    .CLK      (clk),
    .RST      (rst),
    .REQ0     (req[0]),
    .AMT0     (amt[0]),
    .REQ1     (req[1]),
    .AMT1     (amt[1]),
    .GNT0     (gnt0),
    .GNT1     (gnt1),
    .RET_EN   (ret_en),
    .RET_AMT  (ret_amt),
    .LOAD_EN  (load_en),
    .LOAD_VAL (load_val),
    .FREEZE   (freeze),
    .CREDITS  (credits),
    .ERR      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s [%s] observed=%0d expected=%0d", tag, phase, obs, exp);
    end
  endtask

  // One clock: model computes next state from the current inputs, then the
  // edge happens and all outputs are compared on the following negedge.
  task automatic step();
    int nc, np, g, s;
    bit ne, nh;
    bit el [2];
    nc = m_cred; np = m_ptr; ne = m_err; nh = m_hold;
    g  = -1;
    if (!rst) begin
      nc = INIT; np = 0; ne = 0; nh = 0;
    end else begin
      for (int n = 0; n < 2; n++)
        el[n] = req[n] && !m_gnt[n] && (int'(amt[n]) <= m_cred) && (amt[n] != 0)
                && !m_hold && !freeze && !load_en;
      if (el[0] && el[1]) g = m_ptr;
      else if (el[0])     g = 0;
      else if (el[1])     g = 1;
      if (load_en) begin
        if (int'(load_val) > MAXC) begin nc = MAXC; ne = 1; end
        else nc = int'(load_val);
      end else begin
        s = m_cred + (ret_en ? int'(ret_amt) : 0) - ((g >= 0) ? int'(amt[g]) : 0);
        if (s > MAXC)   begin nc = MAXC; ne = 1; end
        else if (s < 0) begin nc = 0;    ne = 1; end
        else nc = s;
        if (g >= 0) np = 1 - g;
      end
      nh = freeze;
    end
    @(posedge clk);
    m_cred = nc; m_ptr = np; m_err = ne; m_hold = nh;
    m_gnt[0] = (g == 0);
    m_gnt[1] = (g == 1);
    @(negedge clk);
    check_eq("gnt0",    gnt0,    m_gnt[0]);
    check_eq("gnt1",    gnt1,    m_gnt[1]);
    check_eq("credits", credits, m_cred);
    check_eq("err",     err,     m_err);
  endtask

  task automatic idle_inputs();
    req[0] = 0; req[1] = 0; amt[0] = 0; amt[1] = 0;
    ret_en = 0; ret_amt = 0; load_en = 0; load_val = 0; freeze = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    step();
    rst = 1;
  endtask

  int gseq[$];
  int age [2];
  bit got;

  initial begin
    rst = 0;
    idle_inputs();
    m_cred = 0; m_ptr = 0; m_err = 0; m_hold = 0;
    m_gnt[0] = 0; m_gnt[1] = 0;
    @(negedge clk);

    // Single grant, then an unaffordable request
    phase = "single";
    do_reset();
    check_eq("rst_credits", credits, INIT);
    check_eq("rst_err", err, 0);
    req[0] = 1; amt[0] = 3;
    step();
    check_eq("s1_gnt0", gnt0, 1);
    check_eq("s1_cred", credits, 1);
    req[0] = 0; req[1] = 1; amt[1] = 2;
    for (int k = 0; k < 3; k++) step();
    check_eq("s1_gnt1_blocked", gnt1, 0);

    // Round-robin alternation until credits run out
    phase = "rr";
    do_reset();
    req[0] = 1; req[1] = 1; amt[0] = 1; amt[1] = 1;
    gseq.delete();
    for (int k = 0; k < 8; k++) begin
      step();
      if (gnt0) gseq.push_back(0);
      if (gnt1) gseq.push_back(1);
    end
    check_eq("rr_count", gseq.size(), 4);
    for (int k = 0; k < 4 && k < gseq.size(); k++) check_eq("rr_order", gseq[k], k % 2);
    check_eq("rr_cred", credits, 0);

    // Overflow saturation and sticky error
    phase = "ovf";
    do_reset();
    load_en = 1; load_val = 250;
    step();
    load_en = 0; ret_en = 1; ret_amt = 10;
    step();
    ret_en = 0;
    check_eq("ovf_cred", credits, 255);
    check_eq("ovf_err", err, 1);
    for (int k = 0; k < 3; k++) step();
    check_eq("ovf_sticky", err, 1);
    rst = 0;
    step();
    rst = 1;
    check_eq("ovf_clr", err, 0);

    // Load has priority over returns and grants
    phase = "load";
    do_reset();
    req[0] = 1; amt[0] = 2; ret_en = 1; ret_amt = 5; load_en = 1; load_val = 7;
    step();
    check_eq("ld_cred", credits, 7);
    check_eq("ld_nogrant", gnt0, 0);
    load_en = 0; ret_en = 0;
    step();
    check_eq("ld_gnt0", gnt0, 1);
    check_eq("ld_cred2", credits, 5);
    req[0] = 0;
    step();

    // Freeze blocks grants but returns still accumulate
    phase = "freeze";
    do_reset();
    freeze = 1; req[0] = 1; amt[0] = 1; ret_en = 1; ret_amt = 3;
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("frz_nogrant", gnt0, 0);
    end
    check_eq("frz_cred", credits, INIT + 12);
    ret_en = 0; freeze = 0;
    got = 0;
    for (int k = 0; k < 2 && !got; k++) begin
      step();
      if (gnt0) got = 1;
    end
    check_eq("frz_gnt_within2", got, 1);
    check_eq("frz_cred2", credits, INIT + 11);
    req[0] = 0;
    step();

    // Reset in the decision cycle cancels the grant
    phase = "rstgrant";
    do_reset();
    req[0] = 1; amt[0] = 1; rst = 0;
    step();
    check_eq("rg_gnt0", gnt0, 0);
    check_eq("rg_cred", credits, INIT);
    rst = 1; req[0] = 0;
    step();
    check_eq("rg_nostray", gnt0, 0);

    // Randomized traffic against the model
    phase = "random";
    do_reset();
    age[0] = 0; age[1] = 0;
    for (int i = 0; i < 4000; i++) begin
      rst      = ($urandom_range(0, 199) != 0);
      load_en  = ($urandom_range(0, 39) == 0);
      load_val = W'($urandom_range(0, 255));
      if ($urandom_range(0, 19) == 0) freeze = !freeze;
      ret_en   = ($urandom_range(0, 3) == 0);
      ret_amt  = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 255))
                                             : W'($urandom_range(0, 5));
      for (int n = 0; n < 2; n++) begin
        if (m_gnt[n]) begin
          req[n] = 0;
        end else if (!req[n]) begin
          if ($urandom_range(0, 2) == 0) begin
            req[n] = 1; amt[n] = W'($urandom_range(0, 6)); age[n] = 0;
          end
        end else begin
          age[n]++;
          if (age[n] > 30) req[n] = 0;
        end
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
